// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Fetch sequencing states: issue a request, wait for its response, hold it under stall.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Bubble encoding: addi x0,x0,0.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // PC value after reset unless the instance overrides it.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response handshake.
interface fetch_unit_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  // Fetch unit side: issues requests, receives grant and response.
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  // Memory side: accepts requests, returns grant and response.
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, and feeds IF/ID with an instruction or a NOP bubble.
// Returned instructions are buffered across stalls; redirects discard
// wrong-path fetches, including a response still in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               valid_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc4_out,
  output logic [31:0]        instr_out
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  hold_buf;
  logic         drop;
  logic [31:0]  pc_plus4;

  // The adder wraps modulo 2^32, so 0xFFFF_FFFC advances to 0.
  assign pc_plus4 = pc + 32'd4;

  // Request and presentation logic; depends only on state and control
  // inputs for imem.req, never on imem.rdata.
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = pc;
    valid_out = 1'b0;
    instr_out = NOP_INSTR;
    pc_out    = pc;
    pc4_out   = pc_plus4;
    case (state)
      S_REQ: begin
        imem.req = !redirect;
      end
      S_WAIT: begin
        // A live response is shown only when IF/ID will take it this cycle.
        if (imem.rvalid && !drop && !redirect && !stall) begin
          valid_out = 1'b1;
          instr_out = imem.rdata;
        end else begin
          valid_out = 1'b0;
        end
      end
      S_HOLD: begin
        if (!redirect) begin
          valid_out = 1'b1;
          instr_out = hold_buf;
        end else begin
          valid_out = 1'b0;
        end
      end
      default: begin
        imem.req  = 1'b0;
        valid_out = 1'b0;
      end
    endcase
  end

  // Fetch sequencer: PC, state, hold buffer and the stale-response drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      hold_buf <= NOP_INSTR;
      drop     <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (imem.gnt) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            if (drop || redirect) begin
              drop  <= 1'b0;
              state <= S_REQ;
              if (redirect) begin
                pc <= redirect_pc;
              end
            end else if (!stall) begin
              pc    <= pc_plus4;
              state <= S_REQ;
            end else begin
              hold_buf <= imem.rdata;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            // The in-flight response belongs to the old path; mark it for discard.
            pc   <= redirect_pc;
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (!stall) begin
            pc    <= pc_plus4;
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
          drop  <= 1'b0;
        end
      endcase
    end
  end

endmodule
